// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: default widths, free-tag encoding and ALU opcodes
// shared by the decoder, the ALU reservation station and the ALU.
package alu_rs_pkg;

    localparam int RS_ENTRIES = 4;
    localparam int RS_TAG_W   = 4;
    localparam int RS_DATA_W  = 32;
    localparam int RS_OP_W    = 5;

    // Tag MSB set means the operand value is present.
    localparam logic [RS_TAG_W-1:0] tagFree =
        {1'b1, {(RS_TAG_W-1){1'b0}}};

    typedef enum logic [RS_OP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9
    } alu_op_e;

endpackage

// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, CDB and issue signals of the ALU station.
// master = decoder/CDB/ALU side, slave = reservation station.
interface alu_rs_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
);
    logic              flush;
    logic              dispEnable;
    logic [OP_W-1:0]   dispOp;
    logic [TAG_W-2:0]  dispDest;
    logic [TAG_W-1:0]  dispTag1;
    logic [TAG_W-1:0]  dispTag2;
    logic [DATA_W-1:0] dispData1;
    logic [DATA_W-1:0] dispData2;
    logic              rsFull;
    logic              cdbValid;
    logic [TAG_W-2:0]  cdbTag;
    logic [DATA_W-1:0] cdbData;
    logic              issueReady;
    logic              issueValid;
    logic [OP_W-1:0]   issueOp;
    logic [TAG_W-2:0]  issueDest;
    logic [DATA_W-1:0] issueA;
    logic [DATA_W-1:0] issueB;

    modport master (
        output flush, dispEnable, dispOp, dispDest,
        output dispTag1, dispTag2, dispData1, dispData2,
        output cdbValid, cdbTag, cdbData, issueReady,
        input  rsFull, issueValid, issueOp, issueDest,
        input  issueA, issueB
    );

    modport slave (
        input  flush, dispEnable, dispOp, dispDest,
        input  dispTag1, dispTag2, dispData1, dispData2,
        input  cdbValid, cdbTag, cdbData, issueReady,
        output rsFull, issueValid, issueOp, issueDest,
        output issueA, issueB
    );

endinterface

// File: rtl/alu_rs_age_picker.sv
// rs_age_picker: age matrix tracking dispatch order of N slots and
// a one-hot grant of the oldest ready slot.
// Ports: clk, rst, alloc_oh (slot allocated), free_oh (slot issued),
//        ready (slot issuable), grant (oldest ready, one-hot).
module rs_age_picker #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] alloc_oh,
    input  logic [N-1:0] free_oh,
    input  logic [N-1:0] ready,
    output logic [N-1:0] grant
);

    // older[i][j] = 1 when slot i was dispatched before slot j.
    logic [N-1:0] older [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (i != j) begin
                        // A new slot is younger than everyone.
                        if (alloc_oh[i])
                            older[i][j] <= 1'b0;
                        else if (alloc_oh[j])
                            older[i][j] <= 1'b1;
                        else if (free_oh[i])
                            older[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // A ready slot wins when no other ready slot is older.
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < N; j++) begin
                if (ready[j] && older[j][i]) grant[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station. Buffers dispatched ops, captures
// CDB results and issues the oldest op whose operands are ready.
// Ports: clk, rst (async, active-high), bus (alu_rs_if.slave).
import alu_rs_pkg::*;

module alu_rs #(
    parameter int ENTRIES = RS_ENTRIES,
    parameter int TAG_W   = RS_TAG_W,
    parameter int DATA_W  = RS_DATA_W,
    parameter int OP_W    = RS_OP_W
) (
    input  logic     clk,
    input  logic     rst,
    alu_rs_if.slave  bus
);

    localparam logic [TAG_W-1:0] TAG_FREE =
        {1'b1, {(TAG_W-1){1'b0}}};

    logic [ENTRIES-1:0] valid;
    logic [OP_W-1:0]    op_q    [ENTRIES];
    logic [TAG_W-2:0]   dest_q  [ENTRIES];
    logic [TAG_W-1:0]   tag1_q  [ENTRIES];
    logic [TAG_W-1:0]   tag2_q  [ENTRIES];
    logic [DATA_W-1:0]  data1_q [ENTRIES];
    logic [DATA_W-1:0]  data2_q [ENTRIES];

    logic [ENTRIES-1:0] wake1, wake2, ready_v;
    logic [ENTRIES-1:0] alloc_oh, grant, issue_oh;
    logic               alloc, fire, byp1, byp2;
    logic [TAG_W-1:0]   in_tag1, in_tag2;
    logic [DATA_W-1:0]  in_data1, in_data2;

    assign bus.rsFull = &valid;
    assign alloc = bus.dispEnable && !bus.rsFull && !bus.flush;

    // Lowest clear bit of valid; zero when full.
    assign alloc_oh = alloc ? (~valid & (valid + 1'b1)) : '0;

    assign byp1 = !bus.dispTag1[TAG_W-1] && bus.cdbValid &&
                  bus.dispTag1[TAG_W-2:0] == bus.cdbTag;
    assign byp2 = !bus.dispTag2[TAG_W-1] && bus.cdbValid &&
                  bus.dispTag2[TAG_W-2:0] == bus.cdbTag;
    assign in_tag1  = byp1 ? TAG_FREE    : bus.dispTag1;
    assign in_tag2  = byp2 ? TAG_FREE    : bus.dispTag2;
    assign in_data1 = byp1 ? bus.cdbData : bus.dispData1;
    assign in_data2 = byp2 ? bus.cdbData : bus.dispData2;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            wake1[i] = valid[i] && !tag1_q[i][TAG_W-1] &&
                       bus.cdbValid &&
                       tag1_q[i][TAG_W-2:0] == bus.cdbTag;
            wake2[i] = valid[i] && !tag2_q[i][TAG_W-1] &&
                       bus.cdbValid &&
                       tag2_q[i][TAG_W-2:0] == bus.cdbTag;
            ready_v[i] = valid[i] && tag1_q[i][TAG_W-1] &&
                         tag2_q[i][TAG_W-1];
        end
    end

    rs_age_picker #(.N(ENTRIES)) u_picker (
        .clk      (clk),
        .rst      (rst),
        .alloc_oh (alloc_oh),
        .free_oh  (issue_oh),
        .ready    (ready_v),
        .grant    (grant)
    );

    assign bus.issueValid = |grant;
    assign fire     = bus.issueValid && bus.issueReady;
    assign issue_oh = fire ? grant : '0;

    always_comb begin
        bus.issueOp   = '0;
        bus.issueDest = '0;
        bus.issueA    = '0;
        bus.issueB    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (grant[i]) begin
                bus.issueOp   = op_q[i];
                bus.issueDest = dest_q[i];
                bus.issueA    = data1_q[i];
                bus.issueB    = data2_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                op_q[i]    <= '0;
                dest_q[i]  <= '0;
                tag1_q[i]  <= TAG_FREE;
                tag2_q[i]  <= TAG_FREE;
                data1_q[i] <= '0;
                data2_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (bus.flush) begin
                    valid[i] <= 1'b0;
                end else if (alloc_oh[i]) begin
                    valid[i]   <= 1'b1;
                    op_q[i]    <= bus.dispOp;
                    dest_q[i]  <= bus.dispDest;
                    tag1_q[i]  <= in_tag1;
                    tag2_q[i]  <= in_tag2;
                    data1_q[i] <= in_data1;
                    data2_q[i] <= in_data2;
                end else begin
                    if (issue_oh[i]) valid[i] <= 1'b0;
                    if (wake1[i]) begin
                        tag1_q[i]  <= TAG_FREE;
                        data1_q[i] <= bus.cdbData;
                    end
                    if (wake2[i]) begin
                        tag2_q[i]  <= TAG_FREE;
                        data2_q[i] <= bus.cdbData;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scenarios plus randomized traffic checked
// against an in-order queue model of the station.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_rs_if bus ();

    alu_rs dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: entries kept in dispatch order.
    typedef struct {
        logic [4:0]  op;
        logic [2:0]  dest;
        logic [3:0]  t1;
        logic [3:0]  t2;
        logic [31:0] d1;
        logic [31:0] d2;
    } ent_t;

    ent_t q[$];
    int tests_run = 0;
    int tests_failed = 0;

    logic        e_valid;
    logic        e_full;
    logic [4:0]  e_op;
    logic [2:0]  e_dest;
    logic [31:0] e_a;
    logic [31:0] e_b;
    int          e_idx;

    function automatic void model_expect();
        e_valid = 1'b0;
        e_op = '0;
        e_dest = '0;
        e_a = '0;
        e_b = '0;
        e_idx = -1;
        e_full = (q.size() == 4);
        for (int i = 0; i < q.size(); i++) begin
            if (e_idx < 0 && q[i].t1[3] && q[i].t2[3]) begin
                e_idx = i;
                e_valid = 1'b1;
                e_op = q[i].op;
                e_dest = q[i].dest;
                e_a = q[i].d1;
                e_b = q[i].d2;
            end
        end
    endfunction

    function automatic void model_update();
        ent_t e;
        bit full;
        full = (q.size() == 4);
        if (bus.flush) begin
            q.delete();
            return;
        end
        if (e_valid && bus.issueReady) q.delete(e_idx);
        if (bus.cdbValid) begin
            for (int i = 0; i < q.size(); i++) begin
                if (!q[i].t1[3] && q[i].t1[2:0] == bus.cdbTag) begin
                    q[i].t1 = 4'h8;
                    q[i].d1 = bus.cdbData;
                end
                if (!q[i].t2[3] && q[i].t2[2:0] == bus.cdbTag) begin
                    q[i].t2 = 4'h8;
                    q[i].d2 = bus.cdbData;
                end
            end
        end
        if (bus.dispEnable && !full) begin
            e.op = bus.dispOp;
            e.dest = bus.dispDest;
            e.t1 = bus.dispTag1;
            e.t2 = bus.dispTag2;
            e.d1 = bus.dispData1;
            e.d2 = bus.dispData2;
            if (!e.t1[3] && bus.cdbValid && e.t1[2:0] == bus.cdbTag) begin
                e.t1 = 4'h8;
                e.d1 = bus.cdbData;
            end
            if (!e.t2[3] && bus.cdbValid && e.t2[2:0] == bus.cdbTag) begin
                e.t2 = 4'h8;
                e.d2 = bus.cdbData;
            end
            q.push_back(e);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_expect();
    endtask

    task automatic idle();
        bus.flush = 1'b0;
        bus.dispEnable = 1'b0;
        bus.dispOp = '0;
        bus.dispDest = '0;
        bus.dispTag1 = 4'h8;
        bus.dispTag2 = 4'h8;
        bus.dispData1 = '0;
        bus.dispData2 = '0;
        bus.cdbValid = 1'b0;
        bus.cdbTag = '0;
        bus.cdbData = '0;
        bus.issueReady = 1'b1;
    endtask

    task automatic clear();
        idle();
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.rsFull !== 1'b0 || bus.issueValid !== 1'b0 ||
            bus.issueA !== 32'd0 || bus.issueB !== 32'd0 ||
            bus.issueDest !== 3'd0 || bus.issueOp !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset: full=%0b v=%0b a=%0h b=%0h want 0 0 0 0",
                     bus.rsFull, bus.issueValid, bus.issueA, bus.issueB);
        end
        rst = 1'b0;
        model_expect();
    endtask

    task automatic test_single();
        clear();
        bus.dispEnable = 1'b1;
        bus.dispOp = ALU_ADD;
        bus.dispDest = 3'd3;
        bus.dispData1 = 32'd5;
        bus.dispData2 = 32'd7;
        cyc();
        bus.dispEnable = 1'b0;
        tests_run++;
        if (bus.issueValid !== 1'b1 || bus.issueA !== 32'd5 ||
            bus.issueB !== 32'd7 || bus.issueDest !== 3'd3 ||
            bus.issueOp !== ALU_ADD) begin
            tests_failed++;
            $display("FAIL single_issue: v=%0b a=%0d b=%0d dest=%0d want 1 5 7 3",
                     bus.issueValid, bus.issueA, bus.issueB, bus.issueDest);
        end
        cyc();
        tests_run++;
        if (bus.issueValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drain: v=%0b want 0", bus.issueValid);
        end
    endtask

    task automatic test_wakeup();
        clear();
        bus.dispEnable = 1'b1;
        bus.dispOp = ALU_SUB;
        bus.dispDest = 3'd1;
        bus.dispTag1 = 4'h2;
        bus.dispData2 = 32'd1;
        cyc();
        idle();
        cyc();
        tests_run++;
        if (bus.issueValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wake_wait: v=%0b want 0", bus.issueValid);
        end
        bus.cdbValid = 1'b1;
        bus.cdbTag = 3'd2;
        bus.cdbData = 32'h1234;
        tests_run++;
        if (bus.issueValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wake_same_cycle: v=%0b want 0", bus.issueValid);
        end
        cyc();
        idle();
        tests_run++;
        if (bus.issueValid !== 1'b1 || bus.issueA !== 32'h1234 ||
            bus.issueB !== 32'd1 || bus.issueDest !== 3'd1) begin
            tests_failed++;
            $display("FAIL wake_issue: v=%0b a=%0h b=%0h dest=%0d want 1 1234 1 1",
                     bus.issueValid, bus.issueA, bus.issueB, bus.issueDest);
        end
        cyc();
    endtask

    task automatic test_bypass();
        clear();
        bus.dispEnable = 1'b1;
        bus.dispOp = ALU_XOR;
        bus.dispDest = 3'd6;
        bus.dispData1 = 32'd3;
        bus.dispTag2 = 4'h5;
        bus.cdbValid = 1'b1;
        bus.cdbTag = 3'd5;
        bus.cdbData = 32'd9;
        cyc();
        idle();
        tests_run++;
        if (bus.issueValid !== 1'b1 || bus.issueA !== 32'd3 ||
            bus.issueB !== 32'd9 || bus.issueDest !== 3'd6) begin
            tests_failed++;
            $display("FAIL bypass: v=%0b a=%0d b=%0d dest=%0d want 1 3 9 6",
                     bus.issueValid, bus.issueA, bus.issueB, bus.issueDest);
        end
        cyc();
    endtask

    task automatic test_full_age();
        logic [2:0] wk [4];
        logic [2:0] ed [4];
        wk = '{3'd3, 3'd1, 3'd2, 3'd0};
        ed = '{3'd7, 3'd5, 3'd5, 3'd4};
        clear();
        bus.issueReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.dispEnable = 1'b1;
            bus.dispOp = ALU_OR;
            bus.dispDest = 3'(k + 4);
            bus.dispTag1 = 4'(k);
            bus.dispData2 = 32'(k * 10);
            cyc();
        end
        bus.dispEnable = 1'b0;
        tests_run++;
        if (bus.rsFull !== 1'b1 || bus.issueValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_fill: full=%0b v=%0b want 1 0",
                     bus.rsFull, bus.issueValid);
        end
        for (int k = 0; k < 4; k++) begin
            bus.cdbValid = 1'b1;
            bus.cdbTag = wk[k];
            bus.cdbData = 32'(100 + k);
            cyc();
            tests_run++;
            if (bus.issueValid !== 1'b1 || bus.issueDest !== ed[k]) begin
                tests_failed++;
                $display("FAIL age_select %0d: v=%0b dest=%0d want 1 %0d",
                         k, bus.issueValid, bus.issueDest, ed[k]);
            end
        end
        bus.cdbValid = 1'b0;
        bus.issueReady = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tests_run++;
            if (bus.issueValid !== 1'b1 || bus.issueDest !== 3'(j + 4) ||
                bus.rsFull !== (j == 0)) begin
                tests_failed++;
                $display("FAIL age_issue %0d: v=%0b dest=%0d full=%0b want 1 %0d %0b",
                         j, bus.issueValid, bus.issueDest, bus.rsFull,
                         j + 4, j == 0);
            end
            cyc();
        end
        tests_run++;
        if (bus.issueValid !== 1'b0 || bus.rsFull !== 1'b0) begin
            tests_failed++;
            $display("FAIL age_drain: v=%0b full=%0b want 0 0",
                     bus.issueValid, bus.rsFull);
        end
    endtask

    task automatic test_back_pressure();
        clear();
        bus.issueReady = 1'b0;
        bus.dispEnable = 1'b1;
        bus.dispOp = ALU_AND;
        bus.dispDest = 3'd2;
        bus.dispData1 = 32'd11;
        bus.dispData2 = 32'd22;
        cyc();
        bus.dispEnable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (bus.issueValid !== 1'b1 || bus.issueA !== 32'd11 ||
                bus.issueB !== 32'd22 || bus.issueDest !== 3'd2) begin
                tests_failed++;
                $display("FAIL hold %0d: v=%0b a=%0d b=%0d dest=%0d want 1 11 22 2",
                         k, bus.issueValid, bus.issueA, bus.issueB,
                         bus.issueDest);
            end
            cyc();
        end
        bus.issueReady = 1'b1;
        cyc();
        tests_run++;
        if (bus.issueValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_release: v=%0b want 0", bus.issueValid);
        end
    endtask

    task automatic test_flush();
        clear();
        for (int k = 0; k < 3; k++) begin
            bus.dispEnable = 1'b1;
            bus.dispDest = 3'(k);
            bus.dispTag1 = 4'h6;
            cyc();
        end
        bus.flush = 1'b1;
        bus.dispEnable = 1'b1;
        bus.dispDest = 3'd7;
        bus.dispTag1 = 4'h8;
        bus.dispData1 = 32'd44;
        cyc();
        idle();
        tests_run++;
        if (bus.issueValid !== 1'b0 || bus.rsFull !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush: v=%0b full=%0b want 0 0",
                     bus.issueValid, bus.rsFull);
        end
        bus.cdbValid = 1'b1;
        bus.cdbTag = 3'd6;
        bus.cdbData = 32'd55;
        cyc();
        idle();
        tests_run++;
        if (bus.issueValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_stale: v=%0b dest=%0d want 0",
                     bus.issueValid, bus.issueDest);
        end
        for (int k = 0; k < 4; k++) begin
            bus.dispEnable = 1'b1;
            bus.dispTag1 = 4'h6;
            cyc();
        end
        idle();
        tests_run++;
        if (bus.rsFull !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_slots: full=%0b want 1", bus.rsFull);
        end
        clear();
    endtask

    task automatic test_random();
        clear();
        for (int c = 0; c < 600; c++) begin
            bus.flush = ($urandom_range(63) == 0);
            bus.dispEnable = !e_full && ($urandom_range(1) == 1);
            bus.dispOp = 5'($urandom_range(9));
            bus.dispDest = 3'($urandom);
            bus.dispTag1 = $urandom_range(1) ? 4'h8 : 4'($urandom_range(7));
            bus.dispTag2 = $urandom_range(1) ? 4'h8 : 4'($urandom_range(7));
            bus.dispData1 = $urandom;
            bus.dispData2 = $urandom;
            bus.cdbValid = ($urandom_range(2) != 0);
            bus.cdbTag = 3'($urandom);
            bus.cdbData = $urandom;
            bus.issueReady = ($urandom_range(3) != 0);
            cyc();
            tests_run++;
            if (bus.issueValid !== e_valid || bus.rsFull !== e_full ||
                bus.issueOp !== e_op || bus.issueDest !== e_dest ||
                bus.issueA !== e_a || bus.issueB !== e_b) begin
                tests_failed++;
                $display("FAIL random %0d: got v=%0b f=%0b op=%0h d=%0h a=%0h b=%0h want v=%0b f=%0b op=%0h d=%0h a=%0h b=%0h",
                         c, bus.issueValid, bus.rsFull, bus.issueOp,
                         bus.issueDest, bus.issueA, bus.issueB,
                         e_valid, e_full, e_op, e_dest, e_a, e_b);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wakeup();
        test_bypass();
        test_full_age();
        test_back_pressure();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
